uart_tx_fifo_param: RTL
=======================

Name: uart_tx_fifo_param

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the uart_RandT path. Contains its own baud divider, a write-side valid/ready FIFO, and configurable data width, bit order, parity and stop bits. Sits between the on-chip byte source and the serial TX pin. Frames are sent back-to-back with no idle gap while the FIFO holds data.

Parameters:
DATA_BITS, 8, payload bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2 stop bits
LSB_FIRST, 1, 1 = data[0] sent first; 0 = data[DATA_BITS-1] sent first
CLKS_PER_BIT, 868, clk cycles per serial bit; minimum 2
FIFO_DEPTH, 4, entries; power of 2, minimum 2

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
s_data  in  DATA_BITS  word to transmit
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept; high whenever fifo_count < FIFO_DEPTH
uart_tx  out  1  serial line; idles high
busy  out  1  high while a frame is on the line (start bit through last stop bit)
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently held

Behaviour:
- Reset (async assert, sync release): uart_tx=1, busy=0, s_ready=1, fifo_count=0. FIFO pointers, bit counter and baud counter cleared. FSM goes to IDLE.
- Assert mid-frame: the line returns high immediately and the in-flight frame and FIFO contents are discarded.
- Write: accepted on a rising edge with s_valid && s_ready. s_data is pushed, and fifo_count increments the same edge. s_valid while full is ignored (no overwrite).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: at an edge where the FIFO is non-empty, pop the head into the shift register, enter START, drive uart_tx=0 and set busy=1. The pop and a push may coincide; fifo_count is then unchanged.
- Each state holds its bit for exactly CLKS_PER_BIT cycles, timed by a baud counter. The counter restarts at 0 on every state or bit change. There is no free-running baud tick, so the start bit is never shortened.
- START -> DATA: send DATA_BITS bits in the order set by LSB_FIRST.
- DATA -> PARITY when PARITY != 0, otherwise DATA -> STOP.
- PARITY bit:
  - Even: XOR of the data bits.
  - Odd: inverse of that XOR.
  - Computed from the popped word, not from live s_data.
- STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- At the end of STOP:
  - FIFO non-empty: pop and re-enter START on the same edge. There is no idle cycle, and busy stays 1.
  - FIFO empty: go to IDLE with busy=0.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Latency: a push to an empty FIFO while IDLE gives a start-bit falling edge 1 clk after the push edge.
- The transmitted word is fixed at pop; later pushes never alter the frame in flight.
- Counters are sized from $clog2 of their maximum value. FIFO pointers wrap modulo FIFO_DEPTH. fifo_count range is 0..FIFO_DEPTH.
- Illegal parameter values are caught by an elaboration-time check, not handled in logic.

Test Plan:
1. CLKS_PER_BIT=4, 8E1, LSB_FIRST=1, push 0xA5 -> uart_tx samples every 4 clks read 0,1,0,1,0,0,1,0,1,0(parity),1(stop). busy is high for exactly 44 clks, then the line idles at 1.
2. Same 0xA5 with PARITY=1 and STOP_BITS=2 -> parity bit=1, line high for 8 clks of stop, frame length 48 clks. With LSB_FIRST=0, the data order is 1,0,1,0,0,1,0,1.
3. FIFO_DEPTH=4, push 5 words on consecutive clks while IDLE:
   - The first word pops at once.
   - Words 2-5 fill the FIFO, so s_ready drops after the 5th push and fifo_count=4.
   - A 6th s_valid is ignored.
   - All 5 frames go out back-to-back: no high gap between stop and the next start, and busy never drops.
4. Push on the same edge as a pop at end of STOP -> fifo_count unchanged, data order preserved, no word lost or duplicated.
5. Assert rst_n low midway through the data bits of frame 2 of 3 -> uart_tx=1, busy=0 and fifo_count=0 immediately. After release, nothing is transmitted until a new push.
6. DATA_BITS=5, PARITY=0, push 0x1F with upper s_data bits irrelevant -> frame 0,1,1,1,1,1,1 lasting 7*CLKS_PER_BIT.

Source files
------------

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with a write-side valid/ready FIFO and its own baud timing.
// Data width, bit order, parity and stop-bit count are set by parameter.
module uart_tx_fifo_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int LSB_FIRST    = 1,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int BAUD_W    = $clog2(STOP_CLKS);
  localparam int BIT_W     = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_END = BAUD_W'(STOP_CLKS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(FIFO_DEPTH);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || (LSB_FIRST != 0 && LSB_FIRST != 1) ||
      CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_fifo_param: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  state_t               r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [BIT_W-1:0]     r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;

  state_t               w_state_nx;
  logic [BAUD_W-1:0]    w_baud_nx;
  logic [BIT_W-1:0]     w_bitcnt_nx;
  logic [DATA_BITS-1:0] w_shift_nx;
  logic                 w_par_nx;
  logic                 w_tx_nx;
  logic                 w_busy_nx;
  logic                 w_load;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_nempty;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_head_par;
  logic                 w_cur_bit;
  logic [DATA_BITS-1:0] w_shift_adv;
  logic                 w_bit_done;
  logic                 w_stop_done;

  assign s_ready    = (r_count < FULL);
  assign w_push     = s_valid && s_ready;
  assign w_nempty   = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_par = (^w_head) ^ (PARITY == 1);
  assign w_bit_done  = (r_baud == BIT_END);
  assign w_stop_done = (r_baud == STOP_END);

  assign uart_tx    = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;

  always_comb begin
    if (LSB_FIRST != 0) begin
      w_cur_bit   = r_shift[0];
      w_shift_adv = {1'b0, r_shift[DATA_BITS-1:1]};
    end else begin
      w_cur_bit   = r_shift[DATA_BITS-1];
      w_shift_adv = {r_shift[DATA_BITS-2:0], 1'b0};
    end
  end

  // Each bit launches at the edge that ends the previous one, so the baud
  // counter restarts on every bit and no shared tick can clip the start bit.
  always_comb begin
    w_state_nx  = r_state;
    w_baud_nx   = r_baud + 1'b1;
    w_bitcnt_nx = r_bitcnt;
    w_shift_nx  = r_shift;
    w_par_nx    = r_par;
    w_tx_nx     = r_tx;
    w_busy_nx   = r_busy;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nx = '0;
        w_load    = w_nempty;
      end
      S_START: begin
        if (w_bit_done) begin
          w_state_nx  = S_DATA;
          w_baud_nx   = '0;
          w_bitcnt_nx = '0;
          w_tx_nx     = w_cur_bit;
          w_shift_nx  = w_shift_adv;
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_baud_nx = '0;
          if (r_bitcnt == LAST_BIT) begin
            if (PARITY != 0) begin
              w_state_nx = S_PARITY;
              w_tx_nx    = r_par;
            end else begin
              w_state_nx = S_STOP;
              w_tx_nx    = 1'b1;
            end
          end else begin
            w_bitcnt_nx = r_bitcnt + 1'b1;
            w_tx_nx     = w_cur_bit;
            w_shift_nx  = w_shift_adv;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_done) begin
          w_state_nx = S_STOP;
          w_baud_nx  = '0;
          w_tx_nx    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_stop_done) begin
          w_baud_nx = '0;
          if (w_nempty) begin
            w_load = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
            w_tx_nx    = 1'b1;
            w_busy_nx  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_baud_nx  = '0;
        w_tx_nx    = 1'b1;
        w_busy_nx  = 1'b0;
      end
    endcase
    if (w_load) begin
      w_pop      = 1'b1;
      w_state_nx = S_START;
      w_baud_nx  = '0;
      w_shift_nx = w_head;
      w_par_nx   = w_head_par;
      w_tx_nx    = 1'b0;
      w_busy_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_baud   <= w_baud_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_shift  <= w_shift_nx;
      r_par    <= w_par_nx;
      r_tx     <= w_tx_nx;
      r_busy   <= w_busy_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

endmodule
